// File: rtl/bp_me_cache_resp_packer_pkg.sv
// Shared message types, sizes and beat-count decode for the cache-side ME response path.
// Consumed by bp_me_cache_resp_packer and the converter that generates per-dword beats.
package bp_me_cache_resp_packer_pkg;

  localparam int unsigned paddr_width_p     = 40;
  localparam int unsigned dword_width_p     = 64;
  localparam int unsigned cce_block_width_p = 512;
  localparam int unsigned beats_lp          = cce_block_width_p / dword_width_p;
  localparam int unsigned cnt_width_lp      = (beats_lp > 1) ? $clog2(beats_lp) : 1;

  typedef enum logic [3:0] {
    e_mem_msg_rd    = 4'd0,
    e_mem_msg_wr    = 4'd1,
    e_mem_msg_uc_rd = 4'd2,
    e_mem_msg_uc_wr = 4'd3
  } bp_mem_msg_e;

  typedef enum logic [2:0] {
    e_mem_msg_size_1  = 3'd0,
    e_mem_msg_size_2  = 3'd1,
    e_mem_msg_size_4  = 3'd2,
    e_mem_msg_size_8  = 3'd3,
    e_mem_msg_size_16 = 3'd4,
    e_mem_msg_size_32 = 3'd5,
    e_mem_msg_size_64 = 3'd6
  } bp_mem_msg_size_e;

  typedef struct packed {
    bp_mem_msg_e              msg_type;
    bp_mem_msg_size_e         size;
    logic [paddr_width_p-1:0] addr;
  } bp_cce_mem_msg_header_s;

  localparam int unsigned cce_mem_msg_header_width_lp = $bits(bp_cce_mem_msg_header_s);

  typedef enum logic [1:0] {
    e_idle    = 2'd0,
    e_collect = 2'd1,
    e_full    = 2'd2
  } bp_me_packer_state_e;

  // Number of dword beats a response carries; writes are always acknowledged in one beat.
  function automatic logic [cnt_width_lp:0] bp_me_resp_beats(input bp_mem_msg_e      msg_type,
                                                             input bp_mem_msg_size_e size);
    logic [cnt_width_lp:0] n;
    n = (cnt_width_lp+1)'(1);
    if (msg_type == e_mem_msg_rd || msg_type == e_mem_msg_uc_rd) begin
      case (size)
        e_mem_msg_size_16: n = (cnt_width_lp+1)'(2);
        e_mem_msg_size_32: n = (cnt_width_lp+1)'(4);
        e_mem_msg_size_64: n = (cnt_width_lp+1)'(8);
        default:           n = (cnt_width_lp+1)'(1);
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/bp_me_cache_resp_packer_counter.sv
// Beat index counter: clear has priority and may be combined with a simultaneous increment.
module bsg_counter_clear_up #(
  parameter  int unsigned max_val_p = 7,
  localparam int unsigned width_lp  = (max_val_p > 0) ? $clog2(max_val_p + 1) : 1
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                clear_i,
  input  logic                up_i,
  output logic [width_lp-1:0] count_o
);

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)   count_o <= '0;
    else if (clear_i) count_o <= width_lp'(up_i);
    else if (up_i)    count_o <= count_o + 1'b1;
  end

endmodule

// File: rtl/bp_me_cache_resp_packer.sv
// Packs per-dword memory response beats into one full-block response per command.
// Optional BP_ME_RESP_PACKER_ADDR_CHECK_EN adds a sticky beat address/type consistency flag.
module bp_me_cache_resp_packer
  import bp_me_cache_resp_packer_pkg::*;
(
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [cce_mem_msg_header_width_lp-1:0] mem_resp_header_i,
  input  logic [dword_width_p-1:0]               mem_resp_data_i,
  input  logic                                   mem_resp_v_i,
  output logic                                   mem_resp_yumi_o,
  output logic [cce_mem_msg_header_width_lp-1:0] block_resp_header_o,
  output logic [cce_block_width_p-1:0]           block_resp_data_o,
  output logic                                   block_resp_v_o,
  input  logic                                   block_resp_yumi_i,
  output logic                                   addr_err_o
);

  bp_cce_mem_msg_header_s hdr_in, hdr_r;
  bp_me_packer_state_e    state_r;
  logic [dword_width_p-1:0] lane_r [beats_lp];
  logic [cnt_width_lp:0]    beats_r, n_first;
  logic [cnt_width_lp-1:0]  cnt, last_idx, lane_mask;
  logic [beats_lp-1:0]      lane_wr_en;
  logic                     accept, v_r;

  assign hdr_in   = bp_cce_mem_msg_header_s'(mem_resp_header_i);
  assign n_first  = bp_me_resp_beats(hdr_in.msg_type, hdr_in.size);
  assign last_idx = cnt_width_lp'(beats_r - 1'b1);

  // The full state is a deliberate bubble: no beat is taken while a block is pending.
  assign mem_resp_yumi_o = reset_n_i & mem_resp_v_i & (state_r != e_full);
  assign accept          = mem_resp_yumi_o;

  bsg_counter_clear_up #(.max_val_p(beats_lp - 1)) beat_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   ((state_r == e_idle && accept) || (state_r == e_full && block_resp_yumi_i)),
    .up_i      (accept),
    .count_o   (cnt)
  );

  assign lane_wr_en = beats_lp'(accept) << ((state_r == e_idle) ? '0 : cnt);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      hdr_r   <= '0;
      beats_r <= '0;
      v_r     <= 1'b0;
    end else begin
      case (state_r)
        e_idle: if (accept) begin
          hdr_r   <= hdr_in;
          beats_r <= n_first;
          if (n_first == (cnt_width_lp+1)'(1)) begin
            state_r <= e_full;
            v_r     <= 1'b1;
          end else begin
            state_r <= e_collect;
          end
        end
        e_collect: if (accept && cnt == last_idx) begin
          state_r <= e_full;
          v_r     <= 1'b1;
        end
        e_full: if (block_resp_yumi_i) begin
          state_r <= e_idle;
          v_r     <= 1'b0;
        end
        default: begin
          state_r <= e_idle;
          v_r     <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the lane storage is reset because the block output must read as zero out of reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < beats_lp; i++) begin
      if (!reset_n_i)         lane_r[i] <= '0;
      else if (lane_wr_en[i]) lane_r[i] <= mem_resp_data_i;
    end
  end

  // Short blocks fill the upper lanes by repeating the received beats (lane i = beat i mod N).
  assign lane_mask = last_idx;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    block_resp_data_o = '0;
    for (int i = 0; i < beats_lp; i++) begin
      block_resp_data_o[i*dword_width_p +: dword_width_p] = lane_r[cnt_width_lp'(i) & lane_mask];
    end
  end

  assign block_resp_header_o = hdr_r;
  assign block_resp_v_o      = v_r;

`ifdef BP_ME_RESP_PACKER_ADDR_CHECK_EN
  logic [paddr_width_p-1:0] exp_addr_r;
  logic                     addr_err_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      exp_addr_r <= '0;
      addr_err_r <= 1'b0;
    end else if (accept) begin
      exp_addr_r <= hdr_in.addr + paddr_width_p'(8);
      if (state_r == e_collect) begin
        exp_addr_r <= exp_addr_r + paddr_width_p'(8);
        if (hdr_in.addr != exp_addr_r || hdr_in.msg_type != hdr_r.msg_type) addr_err_r <= 1'b1;
      end
    end
  end

  assign addr_err_o = addr_err_r;
`else
  assign addr_err_o = 1'b0;
`endif

endmodule
